// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared types and timing constants for the LCD update scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam int LCD_STEP        = 1 << 20;
    localparam int LCD_STEPS       = 128;
    localparam int DEF_TRIG_CYCLES = LCD_STEP;
    // lcd parks again only after the remaining 127 steps of its frame
    localparam int DEF_WAIT_CYCLES = (LCD_STEPS - 1) * LCD_STEP;
    localparam int DEF_TMR_W       = 27;

    localparam int NFIELDS = 7;
    localparam int FIELD_W = 16;
    localparam int DISP_W  = NFIELDS * FIELD_W;

    typedef enum logic [2:0] {
        F_P_SCORE = 3'd0,
        F_D_SCORE = 3'd1,
        F_P_FH    = 3'd2,
        F_P_SH    = 3'd3,
        F_D_FH    = 3'd4,
        F_D_SH    = 3'd5,
        F_BET     = 3'd6
    } field_e;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_TRIG = 2'd2
    } state_e;

    function automatic int field_lsb(input field_e f);
        return int'(f) * FIELD_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_frame_timer.sv
// ============================================================================
// lcd_frame_timer : loadable down-counter, done while the count is zero
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_frame_timer
    import lcd_pkg::*;
#(
    parameter int               TMR_W   = DEF_TMR_W,
    parameter logic [TMR_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_update_scheduler.sv
// ============================================================================
// lcd_update_scheduler : grants screen-update requests and paces lcd frames
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_update_scheduler
    import lcd_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TRIG_CYCLES = DEF_TRIG_CYCLES,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int TMR_W       = DEF_TMR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_i,
    output logic [NREQ-1:0]   ack_o,
    input  logic [DISP_W-1:0] disp_bcd_i,
    output logic [DISP_W-1:0] disp_bcd_o,
    output logic              lcd_trigger_o,
    output logic              busy_o,
    output logic [7:0]        frame_cnt_o
);

    localparam logic [TMR_W-1:0] TRIG_LOAD = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(WAIT_CYCLES - 1);

    state_e             state_q;
    state_e             state_d;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic               tmr_done;
    logic               grant;
    logic [NREQ-1:0]    ack_q;
    logic [DISP_W-1:0]  disp_q;
    logic [7:0]         frame_cnt_q;
    logic               busy_q;
    logic               trig_q;

    // Reset lands in WAIT with the timer loaded: lcd self-runs its init frame.
    lcd_frame_timer #(
        .TMR_W   (TMR_W),
        .RST_VAL (WAIT_LOAD)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        grant        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    grant        = 1'b1;
                    state_d      = ST_TRIG;
                    tmr_load     = 1'b1;
                    tmr_load_val = TRIG_LOAD;
                end
            end
            ST_TRIG: begin
                if (tmr_done) begin
                    state_d      = ST_WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_WAIT;
                tmr_load     = 1'b1;
                tmr_load_val = WAIT_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            ack_q       <= '0;
            disp_q      <= '0;
            frame_cnt_q <= 8'd0;
            busy_q      <= 1'b1;
            trig_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= grant ? req_i : '0;
            if (grant) begin
                disp_q <= disp_bcd_i;
            end
            if ((state_q == ST_WAIT) && tmr_done) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            busy_q <= (state_d != ST_IDLE);
            trig_q <= (state_d == ST_TRIG);
        end
    end

    assign ack_o         = ack_q;
    assign disp_bcd_o    = disp_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign busy_o        = busy_q;
    assign lcd_trigger_o = trig_q;

endmodule

`default_nettype wire
